mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Byte-serial memory controller between the 8-bit RAM/IO port and the core's two memory clients: the instruction queue's fetch port (4-byte instruction on an icache miss) and the store/load buffer's data port (1/2/4-byte loads and committed stores). It arbitrates the two request streams, sequences the byte accesses, assembles little-endian results and returns them with a one-cycle ready pulse. Store writes to the IO region are throttled by `io_buffer_full`.

## Interface
Parameters:
- `IO_BASE`, default 32'h0003_0000: addresses >= IO_BASE are IO; writes there obey `io_buffer_full`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `rdy` in 1: global enable; low freezes all state.
- `clear` in 1: pipeline flush (mispredict).
- `mem_din` in 8: RAM read byte.
- `mem_dout` out 8: RAM write byte.
- `mem_a` out 32: RAM byte address.
- `mem_wr` out 1: 1 = write, 0 = read.
- `io_buffer_full` in 1: IO write buffer full.
- `ins_req` in 1: fetch request, level, held until `ins_ready`.
- `ins_addr` in 32: fetch address.
- `ins_ready` out 1: one-cycle pulse, `ins_data` valid.
- `ins_data` out 32: fetched instruction.
- `data_req` in 1: data request, level, held until `data_ready`.
- `data_wr` in 1: 1 = store, 0 = load.
- `data_addr` in 32: data address.
- `data_len` in 3: byte count, legal values 1, 2, 4.
- `data_wdata` in 32: store data, low `data_len` bytes used.
- `data_ready` out 1: one-cycle pulse, load data valid or store done.
- `data_rdata` out 32: load result, zero-extended. The SLB sign-extends.

## Operation
- States: IDLE, IFETCH, DREAD, DWRITE. A 3-bit byte index `idx`, a latched base address, length and a 32-bit assembly register.
- IDLE: if `data_req` is set, latch the request and go to DREAD or DWRITE. Else if `ins_req` is set, go to IFETCH with len 4. Data has priority over fetch.
- A request is never sampled in a cycle where `ins_ready` or `data_ready` is high. This absorbs the requester's one-cycle deassert latency.
- A started transaction is never preempted by the other client.
- Reads: byte i is addressed at `base+i`. The returned byte goes to bits [8i+7:8i], little-endian. Unread upper bytes are 0.
- Writes: byte i of `data_wdata` goes to `base+i` with `mem_wr`=1.
- After the last byte the controller pulses the matching ready for one cycle and returns to IDLE.
- IO throttle: in DWRITE, if the address is >= IO_BASE and `io_buffer_full`=1, drive `mem_wr`=0 and hold `idx`. Resume when it drops.
- `clear` during IFETCH or DREAD aborts: next state is IDLE, no ready pulse, `mem_wr`=0.
- `clear` during DWRITE is ignored. Committed stores always complete.
- `clear` in IDLE blocks sampling of `ins_req` that cycle.
- `rdy`=0: no state, output or index changes. `rst` overrides `rdy`.
- Address arithmetic is 32-bit with wrap. `idx` counts 0..len-1.
- `mem_wr` is 1 only in DWRITE on a non-stalled byte.

## Timing
- Reset values: state IDLE, `mem_a`=0, `mem_dout`=0, `mem_wr`=0, `ins_ready`=0, `data_ready`=0, `ins_data`=0, `data_rdata`=0.
- All outputs are registered.
- RAM read latency: an address driven in cycle c returns its byte on `mem_din` in cycle c+1.
- Read of N bytes, request sampled at end of cycle 0:
  - addresses in cycles 1..N;
  - bytes captured at end of cycles 2..N+1;
  - ready high in cycle N+2.
  - Fetch: `ins_ready` in cycle 6.
- Write of N bytes, request sampled at end of cycle 0: bytes written in cycles 1..N, `data_ready` in cycle N+1. Each IO stall cycle adds one cycle.
- Back-to-back: the earliest next request is sampled the cycle after the ready pulse.
- `clear` asserted in cycle k aborts a read: state is IDLE in cycle k+1. Bytes arriving afterwards are discarded.

## Test plan
- Fetch: RAM[0x100..0x103]=13,05,A0,00; `ins_req` at 0x100 -> `ins_ready` 6 cycles later with `ins_data`=0x00A00513; `mem_wr` stays 0.
- Load: 2-byte load at 0x201 with RAM=0xFE,0x80 -> `data_rdata`=0x000080FE in cycle 4.
- Store: 4-byte store of 0xDEADBEEF at 0x300 -> bytes EF,BE,AD,DE at 0x300..0x303 in cycles 1-4 with `mem_wr`=1, `data_ready` in cycle 5. A readback returns 0xDEADBEEF.
- Arbitration: `ins_req` and `data_req` raised in the same cycle -> data completes first, fetch starts the cycle after `data_ready`, no duplicated transaction.
- Flush: `clear` in cycle 3 of a fetch -> no `ins_ready`, IDLE next cycle. A 1-byte IO store at IO_BASE given `clear` mid-write -> the write still completes.
- Throttle and freeze:
  - IO store with `io_buffer_full`=1 for 3 cycles -> `mem_wr`=0 during those cycles, the write lands after, `data_ready` 3 cycles late.
  - `rdy`=0 for 2 cycles mid-fetch -> result unchanged, latency +2.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// Bus bundle between mem_ctrl, its two memory clients and the byte-wide RAM/IO port.
// Modports: slave = mem_ctrl side, master = client/RAM side (core or testbench).
interface mem_ctrl_if;
    logic        rdy;
    logic        clear;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;
    logic        ins_req;
    logic [31:0] ins_addr;
    logic        ins_ready;
    logic [31:0] ins_data;
    logic        data_req;
    logic        data_wr;
    logic [31:0] data_addr;
    logic [2:0]  data_len;
    logic [31:0] data_wdata;
    logic        data_ready;
    logic [31:0] data_rdata;

    modport slave (
        input  rdy, clear, mem_din, io_buffer_full,
        input  ins_req, ins_addr,
        input  data_req, data_wr, data_addr, data_len, data_wdata,
        output mem_dout, mem_a, mem_wr,
        output ins_ready, ins_data, data_ready, data_rdata
    );

    modport master (
        output rdy, clear, mem_din, io_buffer_full,
        output ins_req, ins_addr,
        output data_req, data_wr, data_addr, data_len, data_wdata,
        input  mem_dout, mem_a, mem_wr,
        input  ins_ready, ins_data, data_ready, data_rdata
    );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates fetch and data requests onto an
// 8-bit RAM/IO port, assembling little-endian results and pulsing ready.
// Ports: clk, rst (sync, active-high), bus (mem_ctrl_if.slave: rdy, clear,
// RAM port mem_*, io_buffer_full, ins_* fetch client, data_* load/store client).
module mem_ctrl #(
    parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
    input  logic       clk,
    input  logic       rst,
    mem_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, IFETCH, DREAD, DWRITE} state_t;

    state_t      state_q, state_n;
    logic [2:0]  idx_q, idx_n;
    logic [31:0] base_q, base_n;
    logic [2:0]  len_q, len_n;
    logic [31:0] wdata_q, wdata_n;
    logic [31:0] asm_q, asm_n;
    logic [31:0] mem_a_q, mem_a_n;
    logic [7:0]  mem_dout_q, mem_dout_n;
    logic        mem_wr_q, mem_wr_n;
    logic        ins_ready_q, ins_ready_n;
    logic [31:0] ins_data_q, ins_data_n;
    logic        data_ready_q, data_ready_n;
    logic [31:0] data_rdata_q, data_rdata_n;

    // The RAM answers one cycle after the address whether or not we are
    // frozen; keep the byte that arrived right after the last active cycle.
    logic        rdy_q;
    logic [7:0]  din_lat;

    logic [2:0]  idx_nx;
    logic [31:0] addr_nx;
    logic [1:0]  lane;
    logic [7:0]  byte_in;
    logic        busy_out;

    function automatic logic is_io(input logic [31:0] a);
        return a >= IO_BASE;
    endfunction

    always_comb begin
        state_n      = state_q;
        idx_n        = idx_q;
        base_n       = base_q;
        len_n        = len_q;
        wdata_n      = wdata_q;
        asm_n        = asm_q;
        mem_a_n      = mem_a_q;
        mem_dout_n   = mem_dout_q;
        mem_wr_n     = 1'b0;
        ins_ready_n  = 1'b0;
        ins_data_n   = ins_data_q;
        data_ready_n = 1'b0;
        data_rdata_n = data_rdata_q;

        idx_nx   = idx_q + 3'd1;
        addr_nx  = base_q + {29'd0, idx_nx};
        lane     = idx_q[1:0] - 2'd1;
        byte_in  = rdy_q ? bus.mem_din : din_lat;
        busy_out = ins_ready_q | data_ready_q;

        unique case (state_q)
            IDLE: begin
                if (!busy_out) begin
                    if (bus.data_req) begin
                        base_n  = bus.data_addr;
                        len_n   = bus.data_len;
                        wdata_n = bus.data_wdata;
                        idx_n   = 3'd0;
                        asm_n   = 32'd0;
                        mem_a_n = bus.data_addr;
                        if (bus.data_wr) begin
                            state_n    = DWRITE;
                            mem_dout_n = bus.data_wdata[7:0];
                            mem_wr_n   = !(is_io(bus.data_addr)
                                           && bus.io_buffer_full);
                        end else begin
                            state_n = DREAD;
                        end
                    end else if (bus.ins_req && !bus.clear) begin
                        state_n = IFETCH;
                        base_n  = bus.ins_addr;
                        len_n   = 3'd4;
                        idx_n   = 3'd0;
                        asm_n   = 32'd0;
                        mem_a_n = bus.ins_addr;
                    end
                end
            end

            IFETCH, DREAD: begin
                if (bus.clear) begin
                    state_n = IDLE;
                end else begin
                    // idx runs one ahead of the byte on mem_din.
                    if (idx_q != 3'd0) begin
                        asm_n[{lane, 3'b000} +: 8] = byte_in;
                    end
                    if (idx_q == len_q) begin
                        state_n = IDLE;
                        if (state_q == IFETCH) begin
                            ins_ready_n = 1'b1;
                            ins_data_n  = asm_n;
                        end else begin
                            data_ready_n = 1'b1;
                            data_rdata_n = asm_n;
                        end
                    end else begin
                        idx_n = idx_nx;
                        if (idx_nx < len_q) begin
                            mem_a_n = addr_nx;
                        end
                    end
                end
            end

            DWRITE: begin
                // mem_wr_q tells whether byte idx is landing this cycle.
                if (mem_wr_q) begin
                    if (idx_nx == len_q) begin
                        state_n      = IDLE;
                        data_ready_n = 1'b1;
                    end else begin
                        idx_n      = idx_nx;
                        mem_a_n    = addr_nx;
                        mem_dout_n = wdata_q[{idx_nx[1:0], 3'b000} +: 8];
                        mem_wr_n   = !(is_io(addr_nx) && bus.io_buffer_full);
                    end
                end else begin
                    mem_wr_n = !(is_io(mem_a_q) && bus.io_buffer_full);
                end
            end

            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= 3'd0;
            base_q       <= 32'd0;
            len_q        <= 3'd0;
            wdata_q      <= 32'd0;
            asm_q        <= 32'd0;
            mem_a_q      <= 32'd0;
            mem_dout_q   <= 8'd0;
            mem_wr_q     <= 1'b0;
            ins_ready_q  <= 1'b0;
            ins_data_q   <= 32'd0;
            data_ready_q <= 1'b0;
            data_rdata_q <= 32'd0;
        end else if (bus.rdy) begin
            state_q      <= state_n;
            idx_q        <= idx_n;
            base_q       <= base_n;
            len_q        <= len_n;
            wdata_q      <= wdata_n;
            asm_q        <= asm_n;
            mem_a_q      <= mem_a_n;
            mem_dout_q   <= mem_dout_n;
            mem_wr_q     <= mem_wr_n;
            ins_ready_q  <= ins_ready_n;
            ins_data_q   <= ins_data_n;
            data_ready_q <= data_ready_n;
            data_rdata_q <= data_rdata_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_q   <= 1'b0;
            din_lat <= 8'd0;
        end else begin
            rdy_q <= bus.rdy;
            if (rdy_q) begin
                din_lat <= bus.mem_din;
            end
        end
    end

    assign bus.mem_a      = mem_a_q;
    assign bus.mem_dout   = mem_dout_q;
    assign bus.mem_wr     = mem_wr_q;
    assign bus.ins_ready  = ins_ready_q;
    assign bus.ins_data   = ins_data_q;
    assign bus.data_ready = data_ready_q;
    assign bus.data_rdata = data_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: table-driven transactions plus
// hand-written arbitration, flush, throttle and freeze sequences.
module tb_mem_ctrl;

    localparam logic [31:0] IO = 32'h0003_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_ctrl_if bus ();

    mem_ctrl #(.IO_BASE(IO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // RAM model: 4 KiB, aliased on mem_a[11:0], one-cycle read latency.
    logic [7:0]  ram [0:4095];
    logic        pl_en = 1'b0;
    logic [11:0] pl_a  = 12'd0;
    logic [7:0]  pl_d  = 8'd0;

    always @(posedge clk) begin
        if (pl_en) ram[pl_a] <= pl_d;
        else if (bus.mem_wr) ram[bus.mem_a[11:0]] <= bus.mem_dout;
        bus.mem_din <= ram[bus.mem_a[11:0]];
    end

    typedef struct {
        logic        is_ins;
        logic        chk;
        logic [31:0] data;
    } rd_exp_t;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_exp_t;

    typedef struct {
        string       name;
        logic        is_ins;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  len;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    rd_exp_t rq[$];
    wr_exp_t wq[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic seen_ins = 1'b0;
    logic seen_data = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endfunction

    task automatic tick();
        rd_exp_t e;
        wr_exp_t w;
        @(negedge clk);
        cyc++;
        seen_ins  = bus.ins_ready;
        seen_data = bus.data_ready;
        if (bus.mem_wr === 1'b1) begin
            if (wq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wr_unexpected: got write a=%h d=%h, required none",
                         bus.mem_a, bus.mem_dout);
            end else begin
                w = wq.pop_front();
                chk("wr_addr", bus.mem_a, w.a);
                chk("wr_data", {24'd0, bus.mem_dout}, {24'd0, w.d});
            end
        end
        if (bus.ins_ready === 1'b1 || bus.data_ready === 1'b1) begin
            if (rq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rdy_unexpected: got ins=%b data=%b, required none",
                         bus.ins_ready, bus.data_ready);
            end else begin
                e = rq.pop_front();
                chk("rdy_kind", {30'd0, bus.ins_ready, bus.data_ready},
                    e.is_ins ? 32'd2 : 32'd1);
                if (e.chk) begin
                    chk("rdy_data", e.is_ins ? bus.ins_data : bus.data_rdata,
                        e.data);
                end
            end
        end
    endtask

    task automatic issue(input logic is_ins, input logic wr,
                         input logic [31:0] addr, input logic [2:0] len,
                         input logic [31:0] wdata, input logic [31:0] exp);
        rd_exp_t e;
        wr_exp_t w;
        logic [31:0] wd;
        wd = wdata;
        e.is_ins = is_ins;
        e.chk    = !wr;
        e.data   = exp;
        rq.push_back(e);
        if (is_ins) begin
            bus.ins_req  = 1'b1;
            bus.ins_addr = addr;
        end else begin
            if (wr) begin
                for (int i = 0; i < int'(len); i++) begin
                    w.a = addr + i;
                    w.d = wd[8*i +: 8];
                    wq.push_back(w);
                end
            end
            bus.data_req   = 1'b1;
            bus.data_wr    = wr;
            bus.data_addr  = addr;
            bus.data_len   = len;
            bus.data_wdata = wdata;
        end
    endtask

    task automatic wait_ready(input logic is_ins, input int t0,
                              input int lat, input string name);
        int n;
        n = 0;
        while (!(is_ins ? seen_ins : seen_data)) begin
            tick();
            n++;
            if (n > 60) begin
                total++;
                bad++;
                $display("FAIL %s_timeout: got no ready, required ready", name);
                break;
            end
        end
        chk(name, cyc - t0, lat);
        if (is_ins) bus.ins_req = 1'b0;
        else bus.data_req = 1'b0;
    endtask

    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        pl_en = 1'b1;
        pl_a  = a;
        pl_d  = d;
        tick();
        pl_en = 1'b0;
    endtask

    vec_t vecs[10];
    int t0;
    int early;

    initial begin
        bus.rdy = 1'b1;
        bus.clear = 1'b0;
        bus.io_buffer_full = 1'b0;
        bus.ins_req = 1'b0;
        bus.ins_addr = 32'd0;
        bus.data_req = 1'b0;
        bus.data_wr = 1'b0;
        bus.data_addr = 32'd0;
        bus.data_len = 3'd0;
        bus.data_wdata = 32'd0;

        vecs[0] = '{"fetch", 1'b1, 1'b0, 32'h100, 3'd4, 32'd0, 32'h00A00513, 6};
        vecs[1] = '{"load2", 1'b0, 1'b0, 32'h201, 3'd2, 32'd0, 32'h000080FE, 4};
        vecs[2] = '{"store4", 1'b0, 1'b1, 32'h300, 3'd4, 32'hDEADBEEF, 32'd0, 5};
        vecs[3] = '{"rback4", 1'b0, 1'b0, 32'h300, 3'd4, 32'd0, 32'hDEADBEEF, 6};
        vecs[4] = '{"load1", 1'b0, 1'b0, 32'h500, 3'd1, 32'd0, 32'h0000005A, 3};
        vecs[5] = '{"load2b", 1'b0, 1'b0, 32'h100, 3'd2, 32'd0, 32'h00000513, 4};
        vecs[6] = '{"store2", 1'b0, 1'b1, 32'h600, 3'd2, 32'h1234ABCD, 32'd0, 3};
        vecs[7] = '{"rback2", 1'b0, 1'b0, 32'h600, 3'd2, 32'd0, 32'h0000ABCD, 4};
        vecs[8] = '{"store1", 1'b0, 1'b1, 32'h700, 3'd1, 32'hFFFFFF77, 32'd0, 2};
        vecs[9] = '{"wrap2", 1'b0, 1'b0, 32'hFFFFFFFF, 3'd2, 32'd0, 32'h00003CC3, 4};

        poke(12'h100, 8'h13);
        poke(12'h101, 8'h05);
        poke(12'h102, 8'hA0);
        poke(12'h103, 8'h00);
        poke(12'h201, 8'hFE);
        poke(12'h202, 8'h80);
        poke(12'h400, 8'h11);
        poke(12'h401, 8'h22);
        poke(12'h402, 8'h33);
        poke(12'h403, 8'h44);
        poke(12'h500, 8'h5A);
        poke(12'hFFF, 8'hC3);
        poke(12'h000, 8'h3C);

        chk("rst_mem_a", bus.mem_a, 32'd0);
        chk("rst_mem_dout", {24'd0, bus.mem_dout}, 32'd0);
        chk("rst_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
        chk("rst_ins_ready", {31'd0, bus.ins_ready}, 32'd0);
        chk("rst_data_ready", {31'd0, bus.data_ready}, 32'd0);
        chk("rst_ins_data", bus.ins_data, 32'd0);
        chk("rst_data_rdata", bus.data_rdata, 32'd0);

        rst = 1'b0;
        tick();

        foreach (vecs[i]) begin
            t0 = cyc;
            issue(vecs[i].is_ins, vecs[i].wr, vecs[i].addr, vecs[i].len,
                  vecs[i].wdata, vecs[i].exp);
            wait_ready(vecs[i].is_ins, t0, vecs[i].lat, vecs[i].name);
            tick();
        end

        // Same-cycle requests: data first, fetch sampled after data_ready.
        t0 = cyc;
        issue(1'b0, 1'b0, 32'h201, 3'd2, 32'd0, 32'h000080FE);
        issue(1'b1, 1'b0, 32'h400, 3'd4, 32'd0, 32'h44332211);
        wait_ready(1'b0, t0, 4, "arb_data_lat");
        wait_ready(1'b1, t0, 11, "arb_ins_lat");
        for (int i = 0; i < 8; i++) tick();

        // Flush mid-fetch, then a load sampled the very next cycle.
        t0 = cyc;
        bus.ins_req  = 1'b1;
        bus.ins_addr = 32'h100;
        tick();
        tick();
        tick();
        bus.clear   = 1'b1;
        bus.ins_req = 1'b0;
        tick();
        bus.clear = 1'b0;
        chk("flush_cycle", cyc - t0, 4);
        t0 = cyc;
        issue(1'b0, 1'b0, 32'h500, 3'd1, 32'd0, 32'h0000005A);
        wait_ready(1'b0, t0, 3, "flush_load_lat");
        for (int i = 0; i < 6; i++) tick();

        // IO store with clear during the write still completes.
        t0 = cyc;
        issue(1'b0, 1'b1, IO, 3'd1, 32'h000000A5, 32'd0);
        tick();
        bus.clear = 1'b1;
        wait_ready(1'b0, t0, 2, "io_clear_lat");
        bus.clear = 1'b0;
        tick();

        // IO store throttled by io_buffer_full for three cycles.
        t0 = cyc;
        bus.io_buffer_full = 1'b1;
        issue(1'b0, 1'b1, IO + 32'd1, 3'd1, 32'h00000077, 32'd0);
        early = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.mem_wr === 1'b1) early++;
        end
        bus.io_buffer_full = 1'b0;
        chk("throttle_wr_low", early, 0);
        wait_ready(1'b0, t0, 5, "throttle_lat");
        tick();

        t0 = cyc;
        issue(1'b0, 1'b0, IO, 3'd2, 32'd0, 32'h000077A5);
        wait_ready(1'b0, t0, 4, "io_rback_lat");
        tick();

        // Freeze for two cycles mid-fetch.
        t0 = cyc;
        issue(1'b1, 1'b0, 32'h100, 3'd4, 32'd0, 32'h00A00513);
        tick();
        tick();
        tick();
        bus.rdy = 1'b0;
        tick();
        tick();
        bus.rdy = 1'b1;
        wait_ready(1'b1, t0, 8, "freeze_lat");
        for (int i = 0; i < 4; i++) tick();

        chk("rq_empty", rq.size(), 0);
        chk("wq_empty", wq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
